// File: rtl/photon_pipe_scheduler.sv
// Entry scheduler for the photon-transport ring: recirc > launch > bubble arbitration,
// run/drain control and photon accounting. Define SCHED_BUBBLE_CNT_EN to add bubble_count.
module photon_pipe_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_photons,
    input  logic                   stall,
    input  logic                   launch_valid,
    input  logic [DATA_WIDTH-1:0]  launch_data,
    output logic                   launch_ready,
    input  logic                   recirc_valid,
    input  logic [DATA_WIDTH-1:0]  recirc_data,
    input  logic                   retire,
    output logic [DATA_WIDTH-1:0]  pipe_data,
    output logic                   pipe_dead,
    output logic                   pipe_enable,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] launched_count,
    output logic [COUNT_WIDTH-1:0] in_flight,
    output logic                   err_underflow
`ifdef SCHED_BUBBLE_CNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] bubble_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] target;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] in_flight_next;
    logic                   launch_xfer;
    logic                   retire_ok;
    logic                   underflow;
    logic                   start_ok;

    assign pipe_enable = !stall;
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign start_ok    = start && ((state == IDLE) || (state == DONE));

    // Recirculating photons always win the entry slot so ring contents are never dropped.
    always_comb begin
        launch_ready   = (state == RUN) && !stall && !recirc_valid && (launched_count < target);
        launch_xfer    = launch_valid && launch_ready;
        retire_ok      = retire && !stall;
        underflow      = retire_ok && (in_flight == '0);
        pipe_data      = '0;
        pipe_dead      = 1'b1;
        if (recirc_valid) begin
            pipe_data = recirc_data;
            pipe_dead = 1'b0;
        end else if (launch_xfer) begin
            pipe_data = launch_data;
            pipe_dead = 1'b0;
        end
        count_next     = launch_xfer ? launched_count + COUNT_WIDTH'(1) : launched_count;
        in_flight_next = in_flight;
        if (launch_xfer && !retire_ok) begin
            in_flight_next = in_flight + COUNT_WIDTH'(1);
        end else if (!launch_xfer && retire_ok && !underflow) begin
            in_flight_next = in_flight - COUNT_WIDTH'(1);
        end
    end

    // Transitions look at next-cycle counter values so DRAIN/DONE appear the cycle after
    // the event that completes them; stall freezes everything except a new start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            target         <= '0;
            launched_count <= '0;
            in_flight      <= '0;
            err_underflow  <= 1'b0;
        end else begin
            launched_count <= count_next;
            in_flight      <= in_flight_next;
            if (underflow) begin
                err_underflow <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        target         <= num_photons;
                        launched_count <= '0;
                        err_underflow  <= 1'b0;
                        state          <= (num_photons == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!stall && (count_next >= target)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!stall && (in_flight_next == '0)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_BUBBLE_CNT_EN
    // Counts enabled busy cycles where the entry slot went out empty; saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (start_ok) begin
            bubble_count <= '0;
        end else if (!stall && busy && pipe_dead && (bubble_count != '1)) begin
            bubble_count <= bubble_count + COUNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/photon_pipe_scheduler.md
# photon_pipe_scheduler

Entry scheduler for the photon-transport pipeline ring, sitting upstream of the hop/drop/boundary stages. Each cycle it fills the pipeline's single entry slot from one of two sources: a photon returning alive from the end of the ring, or a new photon from the launcher. When neither source is available it inserts a dead bubble. It also counts launches and retirements, applies the global stall, and signals when a run of `num_photons` photons has fully drained.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the photon payload bus, carried opaquely.
- `COUNT_WIDTH`, default 32: width of the photon and in-flight counters.

Ports (clock: `clock`; reset: `reset`, synchronous, active-high):
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a run
- `num_photons`  in  COUNT_WIDTH  photons to launch; sampled on `start`
- `stall`  in  1  downstream back-pressure; freezes the ring
- `launch_valid`  in  1  launcher offers a photon
- `launch_data`  in  DATA_WIDTH  new photon payload
- `launch_ready`  out  1  scheduler accepts the launcher's photon this cycle
- `recirc_valid`  in  1  live photon at the ring exit
- `recirc_data`  in  DATA_WIDTH  recirculating payload
- `retire`  in  1  pulse: one photon terminated at the ring exit
- `pipe_data`  out  DATA_WIDTH  payload presented to the ring entry
- `pipe_dead`  out  1  entry slot holds a bubble
- `pipe_enable`  out  1  global ring enable
- `busy`  out  1  state is RUN or DRAIN
- `done`  out  1  run complete; level signal
- `launched_count`  out  COUNT_WIDTH  photons accepted in this run
- `in_flight`  out  COUNT_WIDTH  live photons currently in the ring
- `err_underflow`  out  1  sticky: `retire` arrived with `in_flight` = 0

## Operation
- States:
  - IDLE: `start` moves to RUN, or directly to DONE if `num_photons` = 0.
  - RUN: moves to DRAIN when `launched_count` reaches the latched target.
  - DRAIN: moves to DONE when `in_flight` = 0.
  - DONE: `start` moves to RUN with the new target (or stays in DONE if the target is 0).
- `start` is ignored in RUN and DRAIN.
- `start` clears `launched_count` and `err_underflow`. It does not clear `in_flight`.
- `pipe_enable` = !`stall`, combinational.
- Entry arbitration is combinational, with fixed priority recirc > launch > bubble:
  - `launch_ready` = (state = RUN) & !`stall` & !`recirc_valid` & (`launched_count` < target).
  - With `recirc_valid`: `pipe_data` = `recirc_data`, `pipe_dead` = 0. This holds in every state, so ring contents are never dropped.
  - Otherwise, on a launch transfer (`launch_valid` & `launch_ready`): `pipe_data` = `launch_data`, `pipe_dead` = 0.
  - Otherwise: `pipe_dead` = 1 and `pipe_data` = 0.
- Counters:
  - A launch transfer increments `launched_count` and `in_flight`.
  - `retire` while `pipe_enable` = 1 decrements `in_flight`.
  - Launch transfer and retire in the same cycle leave `in_flight` unchanged.
  - `retire` while `stall` = 1 is ignored.
  - `retire` with `in_flight` = 0 leaves the counter at 0 and sets `err_underflow`.
- Counter widths: `launched_count` compares unsigned against the latched target. Neither counter wraps: the launch counter stops at the target, and `in_flight` is bounded by it.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `launch_ready` = 0.
  - `launched_count`, `in_flight` = 0.
  - `err_underflow` = 0.
  - `pipe_dead` = 1 unless `recirc_valid` is asserted.
  - `pipe_enable` follows `stall`.
- Reset mid-run aborts immediately. No drain is performed; the ring is reset in parallel by the same `reset`.
- `start` at edge N: state is RUN, and `launch_ready` can be 1, from cycle N+1.
- Launch latency is 0 cycles: payload is on `pipe_data` in the same cycle as the handshake.
- A transfer that makes `launched_count` = target puts the state in DRAIN on the next cycle.
- The cycle after `in_flight` reaches 0 while in DRAIN, the state is DONE: `done` = 1 and `busy` = 0.
- `done` stays high until the next accepted `start`, after which it is 0 from the next cycle.
- Stall has priority over everything:
  - No handshake completes.
  - Counters hold.
  - State transitions RUN→DRAIN and DRAIN→DONE are suppressed.
  - `start` in IDLE or DONE is still accepted.

## Configuration
- `SCHED_BUBBLE_CNT_EN` defined:
  - Adds output `bubble_count` (COUNT_WIDTH), reset to 0 and cleared by an accepted `start`.
  - Increments each enabled cycle in RUN or DRAIN where `pipe_dead` = 1.
  - Saturates at all-ones.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then `start` with `num_photons`=3, `launch_valid` held 1, no recirc -> `launch_ready` high for exactly 3 cycles; `launched_count`=3; DRAIN; 3 `retire` pulses -> `done`=1 one cycle after the last.
- During RUN, `recirc_valid`=1 for 2 cycles with `launch_valid`=1 -> `pipe_data`=`recirc_data`, `launch_ready`=0, `launched_count` unchanged over those cycles.
- `stall`=1 for 4 cycles mid-RUN, with `retire` and `launch_valid` asserted -> `pipe_enable`=0; counters and state frozen; resumes on the cycle `stall` drops.
- Launch transfer and `retire` in the same cycle with `in_flight`=2 -> `in_flight` stays 2; `retire` with `in_flight`=0 -> `err_underflow`=1, counter stays 0.
- `start` with `num_photons`=0 -> DONE next cycle, `launch_ready` never 1; `reset` asserted in DRAIN -> all outputs at reset values next cycle.
- With `SCHED_BUBBLE_CNT_EN`, `num_photons`=2 and `launch_valid` asserted only every 3rd cycle -> `bubble_count`=2 when `launched_count` reaches 2.
